// File: rtl/clk_meter.sv
// Frequency/period meter: synchronises a slow external signal and reports the
// period and high time of each complete cycle in master-clock cycles.
module clk_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8333334
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] LP_CNT_LAST = WIDTH'(TIMEOUT - 1);

  typedef enum logic {S_WAIT_FIRST, S_MEASURE} state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hlatch;

  logic             w_rise;
  logic             w_fall;
  logic [WIDTH-1:0] w_cnt_inc;

  assign w_rise    = r_sync2 & ~r_hist;
  assign w_fall    = ~r_sync2 & r_hist;
  assign w_cnt_inc = r_cnt + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_hist    <= 1'b0;
      r_state   <= S_WAIT_FIRST;
      r_cnt     <= '0;
      r_hlatch  <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      valid   <= 1'b0;
      case (r_state)
        S_WAIT_FIRST: begin
          // The first rise only opens a measurement window; no result yet.
          r_cnt <= '0;
          if (w_rise) r_state <= S_MEASURE;
        end
        S_MEASURE: begin
          r_cnt <= w_cnt_inc;
          if (w_fall) r_hlatch <= w_cnt_inc;
          if (w_rise) begin
            period    <= w_cnt_inc;
            high_time <= r_hlatch;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            r_cnt     <= '0;
          end else if (r_cnt == LP_CNT_LAST) begin
            // A rise landing on the last allowed cycle takes priority above.
            timeout <= 1'b1;
            r_state <= S_WAIT_FIRST;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_WAIT_FIRST;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Self-checking bench for clk_meter: directed waveforms plus an async input,
// compared every cycle against a timestamp-based reference model.
`timescale 1ns/100ps
module tb_clk_meter;

  localparam int W  = 16;
  localparam int TO = 100;

  logic         clk;
  logic         rst;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  clk_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference model: works on the value of sig_in seen at each clk edge and
  // on the edge index of rises/falls; results appear two edges later.
  int           cyc = 0;
  logic         chk_en = 1'b0;
  logic         async_on = 1'b0;
  int           vld_count = 0;
  int           first_vld = 0;
  int           last_vld_cyc = 0;
  int           vld_spacing = 0;
  int           to_rise_cyc = 0;
  logic         to_prev = 1'b0;
  int           n37 = 0, n38 = 0, nother = 0;

  logic         m_prev = 1'b0;
  logic         m_armed = 1'b0;
  int           m_last = 0;
  int           m_fall = 0;
  logic         m_vld = 1'b0;
  logic [W-1:0] m_per = '0;
  logic [W-1:0] m_high = '0;
  logic         m_to = 1'b0;
  logic         p_vld [3] = '{default: 1'b0};
  logic [W-1:0] p_per [3] = '{default: '0};
  logic [W-1:0] p_high[3] = '{default: '0};
  logic         p_to  [3] = '{default: 1'b0};

  always begin
    logic cur;
    logic is_rise;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_prev = 1'b0; m_armed = 1'b0; m_vld = 1'b0;
      m_per = '0; m_high = '0; m_to = 1'b0;
      for (int i = 0; i < 3; i++) begin
        p_vld[i] = 1'b0; p_per[i] = '0; p_high[i] = '0; p_to[i] = 1'b0;
      end
    end else begin
      cur = sig_in;
      is_rise = cur && !m_prev;
      m_vld = 1'b0;
      if (is_rise) begin
        if (m_armed) begin
          m_vld  = 1'b1;
          m_per  = W'(cyc - m_last);
          m_high = W'(m_fall - m_last);
          m_to   = 1'b0;
        end
        m_armed = 1'b1;
        m_last  = cyc;
      end else begin
        if (!cur && m_prev && m_armed) m_fall = cyc;
        if (m_armed && (cyc - m_last) == TO) begin
          m_to    = 1'b1;
          m_armed = 1'b0;
        end
      end
      m_prev = cur;
      for (int i = 2; i > 0; i--) begin
        p_vld[i] = p_vld[i-1]; p_per[i] = p_per[i-1];
        p_high[i] = p_high[i-1]; p_to[i] = p_to[i-1];
      end
      p_vld[0] = m_vld; p_per[0] = m_per; p_high[0] = m_high; p_to[0] = m_to;
    end
    #1;
    if (chk_en) begin
      check("valid", valid, p_vld[2]);
      check("period", period, p_per[2]);
      check("high_time", high_time, p_high[2]);
      check("timeout", timeout, p_to[2]);
      if (valid === 1'b1) begin
        vld_count++;
        vld_spacing  = cyc - last_vld_cyc;
        last_vld_cyc = cyc;
        if (first_vld == 0) first_vld = cyc;
        if (async_on) begin
          if (period == 37) n37++;
          else if (period == 38) n38++;
          else nother++;
        end
      end
      if (timeout === 1'b1 && !to_prev) to_rise_cyc = cyc;
      to_prev = (timeout === 1'b1);
    end
  end

  task automatic step(input logic v, input logic r = 1'b0);
    @(negedge clk);
    sig_in = v;
    rst    = r;
    @(posedge clk);
    #2;
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
  endtask

  initial begin
    int e0;
    int v0;
    sig_in = 1'b0;
    rst    = 1'b1;
    repeat (2) step(1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b1);
    check("rst_period", period, 0);
    check("rst_valid", valid, 0);

    // Idle after reset: no result, no timeout.
    repeat (200) step(1'b0);
    check("idle_vld_count", vld_count, 0);
    check("idle_timeout", timeout, 0);

    // 10 high / 20 low.
    e0 = cyc;
    first_vld = 0;
    v0 = vld_count;
    wave(10, 20, 6);
    check("sq_first_vld_cyc", first_vld, e0 + 31 + 2);
    check("sq_vld_count", vld_count - v0, 5);
    check("sq_spacing", vld_spacing, 30);
    check("sq_period", period, 30);
    check("sq_high", high_time, 10);

    // 100 accepted, 101 times out and only re-arms, next 100 recovers.
    v0 = vld_count;
    wave(50, 50, 2);
    wave(51, 50, 1);
    wave(50, 50, 1);
    check("p101_timeout", timeout, 1);
    check("p101_period", period, 100);
    wave(50, 50, 1);
    check("p100_timeout_clr", timeout, 0);
    check("p100_period", period, 100);
    check("p100_vld_count", vld_count - v0, 4);

    // Input stuck high.
    wave(10, 20, 4);
    e0 = cyc;
    repeat (150) step(1'b1);
    check("stuck_to_cyc", to_rise_cyc, e0 + 1 + 2 + TO);
    check("stuck_timeout", timeout, 1);
    check("stuck_period", period, 30);
    check("stuck_high", high_time, 10);
    repeat (20) step(1'b0);
    wave(10, 20, 3);
    check("restart_timeout", timeout, 0);
    check("restart_period", period, 30);
    check("restart_high", high_time, 10);

    // Reset in the middle of a period.
    wave(10, 20, 2);
    repeat (10) step(1'b1);
    repeat (5) step(1'b0);
    step(1'b0, 1'b1);
    check("midrst_period", period, 0);
    check("midrst_high", high_time, 0);
    check("midrst_timeout", timeout, 0);
    repeat (15) step(1'b0);
    v0 = vld_count;
    wave(10, 20, 3);
    check("postrst_vld_count", vld_count - v0, 2);
    check("postrst_period", period, 30);

    // Minimum period.
    wave(1, 1, 20);
    check("min_period", period, 2);
    check("min_high", high_time, 1);

    // Asynchronous input, 37.3 clk cycles per period.
    #1.3;
    fork
      repeat (60) #186.5 sig_in = ~sig_in;
      begin
        repeat (100) @(posedge clk);
        async_on = 1'b1;
      end
    join
    async_on = 1'b0;
    check("async_37_seen", (n37 > 0), 1);
    check("async_38_seen", (n38 > 0), 1);
    check("async_other", nother, 0);

    repeat (150) step(1'b0);
    check("final_timeout", timeout, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
